truth_table_sweeper: RTL

- Parametrised successor to the fixed 2-input gate blocks (e.g. f = a'.b).
- Holds an N-input Boolean function as a 2^N-bit truth table (LUT) and evaluates it.
- On request, walks all 2^N minterms in sequence and streams (minterm, value) pairs over a valid/ready handshake.
- Accumulates the count of true minterms and signals completion; used as a self-checking source for gate-level benches and as a programmable gate.

---
 rtl/truth_table_sweeper.sv | 94 +++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: holds an N-input Boolean function as a 2^N-bit truth
// table, evaluates it directly, and on request streams every (minterm, value)
// pair over a valid/ready handshake while counting the true minterms.
module truth_table_sweeper #(
   parameter int N    = 2,
   parameter bit GRAY = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [(1<<N)-1:0]   lut,
   input  logic [N-1:0]        eval_in,
   output logic                eval_out,
   output logic                busy,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [N-1:0]        m_index,
   output logic                m_value,
   output logic                done,
   output logic [N:0]          ones_count
);

   localparam logic [N-1:0] LAST_STEP = {N{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [N-1:0]        step;
   logic [(1<<N)-1:0]   lut_q;
   logic                xfer;

   // Binary-reflected Gray code of a step count.
   function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Minterm ordering and table lookups; both read the latched table only.
   assign m_index  = GRAY ? to_gray(step) : step;
   assign m_value  = lut_q[m_index];
   assign eval_out = lut_q[eval_in];
   assign xfer     = m_valid & m_ready;

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      m_valid   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy    = 1'b1;
            m_valid = 1'b1;
            // Terminal compare happens before the step increment, so the
            // N-bit step counter never wraps.
            if (m_ready && (step == LAST_STEP)) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register, table capture, step counter and ones accumulator.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         lut_q      <= '0;
         step       <= '0;
         ones_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            lut_q      <= lut;
            step       <= '0;
            ones_count <= '0;
         end else if (state == RUN && xfer) begin
            // N+1 bits hold the all-ones result 2^N without wrapping.
            ones_count <= ones_count + {{N{1'b0}}, m_value};
            if (step != LAST_STEP) step <= step + 1'b1;
         end
      end
   end

endmodule
